ws2812_serializer: RTL

WS2812_SERIALIZER -- requirements
Module: ws2812_serializer

---
 rtl/ws2812_serializer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ws2812_serializer.sv
// WS2812 one-wire serializer: bytes in (MSB first), programmable bit timing, frame-end reset phase.
// Optional: define WS2812_UNDERRUN_ABORT_EN to abort a starved frame into the reset phase.
module ws2812_serializer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [CNT_W-1:0] byte_num_in,
    input  logic             byte_vld_in,
    input  logic [7:0]       byte_data_in,
    output logic             byte_rdy_out,
    input  logic [7:0]       t1_h_cnt_in,
    input  logic [7:0]       t1_l_cnt_in,
    input  logic [7:0]       t0_h_cnt_in,
    input  logic [7:0]       t0_l_cnt_in,
    input  logic [15:0]      rst_cnt_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             ws2812_data_out
);

    typedef enum logic [2:0] {IDLE, FETCH, BIT_H, BIT_L, RST} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] acc_q;
    logic [7:0]       t1_h_q, t1_l_q, t0_h_q, t0_l_q;
    logic [15:0]      rst_len_q;
    logic [15:0]      rst_q;
    logic [7:0]       shift_q;
    logic [7:0]       pf_q;
    logic             pf_full_q;
    logic [7:0]       phase_q;
    logic [2:0]       bit_idx_q;
    logic             line_q;
    logic             busy_q;
    logic             done_q;

    logic             owed_d;
    logic             xfer_d;
    logic [7:0]       load_h_d;
    logic [7:0]       next_h_d;
    logic [7:0]       cur_l_d;
    logic [15:0]      rst_start_d;
    logic [15:0]      rst_load_d;

    // Counters hold "cycles remaining minus one", so a programmed 0 behaves like 1.
    function automatic logic [7:0] phase_len(input logic [7:0] t);
        return (t == 8'd0) ? 8'd0 : t - 8'd1;
    endfunction

    function automatic logic [15:0] rst_len(input logic [15:0] t);
        return (t == 16'd0) ? 16'd0 : t - 16'd1;
    endfunction

    assign owed_d       = (acc_q < num_q);
    assign byte_rdy_out = !pf_full_q && owed_d &&
                          (state_q == FETCH || state_q == BIT_H || state_q == BIT_L);
    assign xfer_d       = byte_vld_in && byte_rdy_out;

    assign load_h_d    = phase_len(pf_q[7]    ? t1_h_q : t0_h_q);
    assign next_h_d    = phase_len(shift_q[6] ? t1_h_q : t0_h_q);
    assign cur_l_d     = phase_len(shift_q[7] ? t1_l_q : t0_l_q);
    assign rst_start_d = rst_len(rst_cnt_in);
    assign rst_load_d  = rst_len(rst_len_q);

    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign ws2812_data_out = line_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: the data registers (shift/prefetch) are reset too, so a fresh frame
            // can never leak stale pixel bits onto the line.
            state_q   <= IDLE;
            num_q     <= '0;
            acc_q     <= '0;
            t1_h_q    <= 8'd0;
            t1_l_q    <= 8'd0;
            t0_h_q    <= 8'd0;
            t0_l_q    <= 8'd0;
            rst_len_q <= 16'd0;
            rst_q     <= 16'd0;
            shift_q   <= 8'd0;
            pf_q      <= 8'd0;
            pf_full_q <= 1'b0;
            phase_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            line_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (xfer_d) begin
                pf_q      <= byte_data_in;
                pf_full_q <= 1'b1;
                acc_q     <= acc_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    line_q <= 1'b0;
                    // busy_q is still set during the done cycle, which blocks a start there.
                    if (start_in && !busy_q) begin
                        busy_q    <= 1'b1;
                        num_q     <= byte_num_in;
                        t1_h_q    <= t1_h_cnt_in;
                        t1_l_q    <= t1_l_cnt_in;
                        t0_h_q    <= t0_h_cnt_in;
                        t0_l_q    <= t0_l_cnt_in;
                        rst_len_q <= rst_cnt_in;
                        acc_q     <= '0;
                        pf_full_q <= 1'b0;
                        if (byte_num_in == '0) begin
                            state_q <= RST;
                            rst_q   <= rst_start_d;
                        end else begin
                            state_q <= FETCH;
                            rst_q   <= 16'd0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                FETCH: begin
                    if (pf_full_q) begin
                        state_q   <= BIT_H;
                        line_q    <= 1'b1;
                        shift_q   <= pf_q;
                        pf_full_q <= 1'b0;
                        bit_idx_q <= 3'd7;
                        phase_q   <= load_h_d;
                    end
`ifdef WS2812_UNDERRUN_ABORT_EN
                    else if (rst_q == rst_len_q) begin
                        state_q   <= RST;
                        rst_q     <= rst_load_d;
                        pf_full_q <= 1'b0;
                    end else begin
                        rst_q <= rst_q + 16'd1;
                    end
`endif
                end
                BIT_H: begin
                    if (phase_q == 8'd0) begin
                        state_q <= BIT_L;
                        line_q  <= 1'b0;
                        phase_q <= cur_l_d;
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end
                BIT_L: begin
                    if (phase_q != 8'd0) begin
                        phase_q <= phase_q - 8'd1;
                    end else if (bit_idx_q != 3'd0) begin
                        state_q   <= BIT_H;
                        line_q    <= 1'b1;
                        shift_q   <= {shift_q[6:0], 1'b0};
                        bit_idx_q <= bit_idx_q - 3'd1;
                        phase_q   <= next_h_d;
                    end else if (pf_full_q) begin
                        state_q   <= BIT_H;
                        line_q    <= 1'b1;
                        shift_q   <= pf_q;
                        pf_full_q <= 1'b0;
                        bit_idx_q <= 3'd7;
                        phase_q   <= load_h_d;
                    end else if (owed_d) begin
                        state_q <= FETCH;
                        rst_q   <= 16'd0;
                    end else begin
                        state_q <= RST;
                        rst_q   <= rst_load_d;
                    end
                end
                RST: begin
                    line_q <= 1'b0;
                    if (rst_q == 16'd0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        rst_q <= rst_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    line_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
